// File: rtl/seg7_ascii_capture_pkg.sv
// Shared constants, FSM state type and glyph decode table for the seven-segment to ASCII capture block.
// Segment buses are active-low, bit0 = a .. bit6 = g.
package seg7_ascii_capture_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 5;
    localparam int unsigned FRAME_W = SEG_W * DIGITS;
    localparam int unsigned ASCII_W = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [SEG_W-1:0]   BLANK_PAT    = 7'h7F;
    localparam logic [ASCII_W-1:0] BLANK_CHAR   = 8'h20;
    localparam logic [ASCII_W-1:0] UNKNOWN_CHAR = 8'h3F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [ASCII_W-1:0] code;
        logic               bad;
    } glyph_t;

    // Colliding shapes resolve to the digit; letters come out uppercase.
    function automatic glyph_t decode_glyph(input logic [SEG_W-1:0] pat);
        glyph_t g;
        g.code = UNKNOWN_CHAR;
        g.bad  = 1'b0;
        case (pat)
            7'h40: g.code = 8'h30;
            7'h79: g.code = 8'h31;
            7'h24: g.code = 8'h32;
            7'h30: g.code = 8'h33;
            7'h19: g.code = 8'h34;
            7'h12: g.code = 8'h35;
            7'h02: g.code = 8'h36;
            7'h78: g.code = 8'h37;
            7'h00: g.code = 8'h38;
            7'h10: g.code = 8'h39;
            7'h08: g.code = 8'h41;
            7'h03: g.code = 8'h42;
            7'h46: g.code = 8'h43;
            7'h21: g.code = 8'h44;
            7'h06: g.code = 8'h45;
            7'h0E: g.code = 8'h46;
            7'h09: g.code = 8'h48;
            7'h61: g.code = 8'h4A;
            7'h47: g.code = 8'h4C;
            7'h2B: g.code = 8'h4E;
            7'h23: g.code = 8'h4F;
            7'h0C: g.code = 8'h50;
            7'h2F: g.code = 8'h52;
            7'h07: g.code = 8'h54;
            7'h41: g.code = 8'h55;
            7'h11: g.code = 8'h59;
            7'h3F: g.code = 8'h2D;
            BLANK_PAT: g.code = BLANK_CHAR;
            default: g.bad = 1'b1;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of one active-low seven-segment pattern into an ASCII byte and an unknown flag.
module seg7_glyph_decode
    import seg7_ascii_capture_pkg::*;
(
    input  logic [SEG_W-1:0]   pat_i,
    output logic [ASCII_W-1:0] ascii_c_o,
    output logic               bad_c_o
);

    glyph_t glyph_c;

    always_comb begin
        glyph_c = decode_glyph(pat_i);
    end

    assign ascii_c_o = glyph_c.code;
    assign bad_c_o   = glyph_c.bad;

endmodule

// File: rtl/seg7_ascii_capture.sv
// Captures a stable five-digit seven-segment frame and streams it out as ASCII beats, leftmost digit first,
// over a valid/ready handshake. Identical frames are sent only once.
module seg7_ascii_capture
    import seg7_ascii_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SEG_W-1:0]   hex_seg4_i,
    input  logic [SEG_W-1:0]   hex_seg3_i,
    input  logic [SEG_W-1:0]   hex_seg2_i,
    input  logic [SEG_W-1:0]   hex_seg1_i,
    input  logic [SEG_W-1:0]   hex_seg0_i,
    input  logic               ascii_ready_i,
    output logic [ASCII_W-1:0] ascii_code_o,
    output logic               ascii_valid_o,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic               bad_glyph_o
);

    localparam logic [IDX_W-1:0]   IDX_FIRST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]   CNT_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [FRAME_W-1:0] BLANK_FRAME = {DIGITS{BLANK_PAT}};

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   sample_q, sample_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 first_sent_q, first_sent_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [ASCII_W-1:0]   code_q, code_d;
    logic                 start_q, start_d;
    logic                 end_q, end_d;
    logic                 bad_q, bad_d;

    logic [FRAME_W-1:0]   live_c;
    logic                 stable_c;
    logic                 accept_c;
    logic [IDX_W-1:0]     sel_idx_c;
    logic [SEG_W-1:0]     digit_c;
    logic [ASCII_W-1:0]   ascii_c;
    logic                 bad_c;

    assign live_c   = {hex_seg4_i, hex_seg3_i, hex_seg2_i, hex_seg1_i, hex_seg0_i};
    assign stable_c = (cnt_q == CNT_STABLE);
    assign accept_c = valid_q && ascii_ready_i;

    // Digit to present next: the current index on the first beat, the following one on accept.
    assign sel_idx_c = accept_c ? (idx_q - IDX_W'(1)) : idx_q;

    always_comb begin
        digit_c = BLANK_PAT;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel_idx_c == IDX_W'(i)) begin
                digit_c = frame_q[i*SEG_W +: SEG_W];
            end
        end
    end

    seg7_glyph_decode u_decode (
        .pat_i     (digit_c),
        .ascii_c_o (ascii_c),
        .bad_c_o   (bad_c)
    );

    always_comb begin
        state_d      = state_q;
        sample_d     = live_c;
        frame_d      = frame_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        first_sent_d = first_sent_q;
        idx_d        = idx_q;
        valid_d      = valid_q;
        code_d       = code_q;
        start_d      = start_q;
        end_d        = end_q;
        bad_d        = bad_q;

        if (live_c != sample_q) begin
            cnt_d = '0;
        end else if (!stable_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (stable_c && (!first_sent_q || (sample_q != last_q))) begin
                    state_d      = ST_SEND;
                    frame_d      = sample_q;
                    last_d       = sample_q;
                    first_sent_d = 1'b1;
                    idx_d        = IDX_FIRST;
                end
            end
            ST_SEND: begin
                if (accept_c && (idx_q == '0)) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    start_d = 1'b0;
                    end_d   = 1'b0;
                    bad_d   = 1'b0;
                end else if (!valid_q || accept_c) begin
                    valid_d = 1'b1;
                    code_d  = ascii_c;
                    bad_d   = bad_c;
                    start_d = (sel_idx_c == IDX_FIRST);
                    end_d   = (sel_idx_c == '0);
                    idx_d   = sel_idx_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sample_q     <= BLANK_FRAME;
            frame_q      <= BLANK_FRAME;
            last_q       <= BLANK_FRAME;
            cnt_q        <= '0;
            first_sent_q <= 1'b0;
            idx_q        <= IDX_FIRST;
            valid_q      <= 1'b0;
            code_q       <= '0;
            start_q      <= 1'b0;
            end_q        <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            frame_q      <= frame_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            first_sent_q <= first_sent_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            start_q      <= start_d;
            end_q        <= end_d;
            bad_q        <= bad_d;
        end
    end

    assign ascii_code_o  = code_q;
    assign ascii_valid_o = valid_q;
    assign frame_start_o = start_q;
    assign frame_end_o   = end_q;
    assign bad_glyph_o   = bad_q;

endmodule
